// File: rtl/flexbex_ibex_if_stage.sv
// flexbex_ibex_if_stage
// Instruction-fetch stage between the prefetch buffer and the decode stage.
// Owns the PC-set mux, drives the prefetch buffer controls and holds the
// IF/ID pipeline register with a valid/ready handshake towards ID.
//
// Optional feature: define FLEXBEX_IF_FETCH_CNT_EN to build a 32-bit counter
// of instructions handed to ID on fetch_cnt_o. Without it, fetch_cnt_o is 0.
module flexbex_ibex_if_stage #(
    parameter int BOOT_ALIGN = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_i,
    input  logic [31:0] boot_addr_i,

    input  logic        pc_set_i,
    input  logic [1:0]  pc_mux_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] exc_pc_i,
    input  logic [31:0] epc_i,

    input  logic        halt_if_i,
    input  logic        id_ready_i,

    output logic        pf_req_o,
    output logic        pf_branch_o,
    output logic [31:0] pf_addr_o,
    output logic        pf_ready_o,
    input  logic        pf_valid_i,
    input  logic [31:0] pf_rdata_i,
    input  logic [31:0] pf_addr_i,
    input  logic        pf_busy_i,

    output logic        instr_valid_id_o,
    output logic [31:0] instr_rdata_id_o,
    output logic [31:0] pc_id_o,
    output logic        is_compressed_id_o,
    output logic        illegal_c_insn_id_o,
    output logic        instr_new_id_o,
    output logic        if_busy_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BOOT = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_JUMP = 2'd1,
        PC_EXC  = 2'd2,
        PC_EPC  = 2'd3
    } pc_sel_e;

    state_e      state_q;
    state_e      state_d;

    logic [31:0] boot_addr_aligned;
    logic [31:0] redirect_addr;
    logic        transfer;

    logic        valid_q;
    logic [31:0] rdata_q;
    logic [31:0] pc_q;
    logic        compressed_q;
    logic        illegal_c_q;
    logic        new_q;

    assign boot_addr_aligned = {boot_addr_i[31:BOOT_ALIGN], {BOOT_ALIGN{1'b0}}};

    // Redirect source select; every target is halfword aligned.
    always_comb begin
        redirect_addr = boot_addr_aligned;
        unique case (pc_sel_e'(pc_mux_i))
            PC_BOOT: redirect_addr = boot_addr_aligned;
            PC_JUMP: redirect_addr = jump_target_i;
            PC_EXC:  redirect_addr = exc_pc_i;
            PC_EPC:  redirect_addr = epc_i;
            default: redirect_addr = boot_addr_aligned;
        endcase
        redirect_addr[0] = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and prefetch request/branch/address outputs.
    always_comb begin
        // NOTE: every output is given a default first so no path through the
        // case leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        pf_req_o    = 1'b0;
        pf_branch_o = 1'b0;
        pf_addr_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    // A redirect arriving with the first request skips BOOT.
                    state_d = pc_set_i ? RUN : BOOT;
                    if (pc_set_i) begin
                        pf_branch_o = 1'b1;
                        pf_addr_o   = redirect_addr;
                    end
                end
            end
            BOOT: begin
                pf_req_o    = 1'b1;
                pf_branch_o = 1'b1;
                pf_addr_o   = pc_set_i ? redirect_addr : boot_addr_aligned;
                state_d     = RUN;
            end
            RUN: begin
                pf_req_o = req_i;
                if (pc_set_i) begin
                    pf_branch_o = 1'b1;
                    pf_addr_o   = redirect_addr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Accept from the prefetch buffer only when ID can take the slot and
    // no flush or halt is pending.
    assign pf_ready_o = ~halt_if_i & ~pc_set_i & (~valid_q | id_ready_i);
    assign transfer   = pf_valid_i & pf_ready_o;

    // IF/ID pipeline register; a flush drops valid but leaves the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data fields are reset too because they are visible
            // outputs that must read as zero straight out of reset.
            valid_q      <= 1'b0;
            rdata_q      <= '0;
            pc_q         <= '0;
            compressed_q <= 1'b0;
            illegal_c_q  <= 1'b0;
            new_q        <= 1'b0;
        end else begin
            if (transfer) begin
                valid_q      <= 1'b1;
                rdata_q      <= pf_rdata_i;
                pc_q         <= pf_addr_i;
                compressed_q <= (pf_rdata_i[1:0] != 2'b11);
                illegal_c_q  <= (pf_rdata_i[1:0] != 2'b11) && (pf_rdata_i[15:0] == 16'h0000);
            end else if (id_ready_i) begin
                valid_q <= 1'b0;
            end
            if (pc_set_i) valid_q <= 1'b0;
            new_q <= transfer & ~pc_set_i;
        end
    end

    assign instr_valid_id_o    = valid_q;
    assign instr_rdata_id_o    = rdata_q;
    assign pc_id_o             = pc_q;
    assign is_compressed_id_o  = compressed_q;
    assign illegal_c_insn_id_o = illegal_c_q;
    assign instr_new_id_o      = new_q;
    assign if_busy_o           = pf_busy_i | (state_q == BOOT);

`ifdef FLEXBEX_IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    // Count instructions handed to ID; survives flushes, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)           fetch_cnt_q <= '0;
        else if (transfer) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end

    assign fetch_cnt_o = fetch_cnt_q;
`else
    assign fetch_cnt_o = '0;
`endif

endmodule

// File: tb/tb_flexbex_ibex_if_stage.sv
// Testbench for flexbex_ibex_if_stage: directed vectors, scoreboard for
// instructions loaded into IF/ID, direct checks for the control outputs.
module tb_flexbex_ibex_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [31:0] boot_addr_i;
    logic        pc_set_i;
    logic [1:0]  pc_mux_i;
    logic [31:0] jump_target_i;
    logic [31:0] exc_pc_i;
    logic [31:0] epc_i;
    logic        halt_if_i;
    logic        id_ready_i;
    logic        pf_req_o;
    logic        pf_branch_o;
    logic [31:0] pf_addr_o;
    logic        pf_ready_o;
    logic        pf_valid_i;
    logic [31:0] pf_rdata_i;
    logic [31:0] pf_addr_i;
    logic        pf_busy_i;
    logic        instr_valid_id_o;
    logic [31:0] instr_rdata_id_o;
    logic [31:0] pc_id_o;
    logic        is_compressed_id_o;
    logic        illegal_c_insn_id_o;
    logic        instr_new_id_o;
    logic        if_busy_o;
    logic [31:0] fetch_cnt_o;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] pc;
        logic        c;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_xfer = 0;

    always #5 clk = ~clk;

    flexbex_ibex_if_stage #(.BOOT_ALIGN(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_i               (req_i),
        .boot_addr_i         (boot_addr_i),
        .pc_set_i            (pc_set_i),
        .pc_mux_i            (pc_mux_i),
        .jump_target_i       (jump_target_i),
        .exc_pc_i            (exc_pc_i),
        .epc_i               (epc_i),
        .halt_if_i           (halt_if_i),
        .id_ready_i          (id_ready_i),
        .pf_req_o            (pf_req_o),
        .pf_branch_o         (pf_branch_o),
        .pf_addr_o           (pf_addr_o),
        .pf_ready_o          (pf_ready_o),
        .pf_valid_i          (pf_valid_i),
        .pf_rdata_i          (pf_rdata_i),
        .pf_addr_i           (pf_addr_i),
        .pf_busy_i           (pf_busy_i),
        .instr_valid_id_o    (instr_valid_id_o),
        .instr_rdata_id_o    (instr_rdata_id_o),
        .pc_id_o             (pc_id_o),
        .is_compressed_id_o  (is_compressed_id_o),
        .illegal_c_insn_id_o (illegal_c_insn_id_o),
        .instr_new_id_o      (instr_new_id_o),
        .if_busy_o           (if_busy_o),
        .fetch_cnt_o         (fetch_cnt_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction that the bench expects to be accepted this cycle.
    task automatic offer(input logic [31:0] rdata, input logic [31:0] pc,
                         input logic c, input logic ill);
        exp_t e;
        pf_valid_i = 1'b1;
        pf_rdata_i = rdata;
        pf_addr_i  = pc;
        e.rdata = rdata;
        e.pc    = pc;
        e.c     = c;
        e.ill   = ill;
        sb.push_back(e);
        n_xfer++;
    endtask

    // Monitor: whenever IF/ID reports a fresh load, compare against the
    // oldest expected instruction.
    always @(negedge clk) begin
        if (instr_new_id_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got load pc 0x%08h expected no load", pc_id_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_valid", {31'd0, instr_valid_id_o}, 32'd1);
                check("sb_rdata", instr_rdata_id_o, e.rdata);
                check("sb_pc",    pc_id_o, e.pc);
                check("sb_c",     {31'd0, is_compressed_id_o}, {31'd0, e.c});
                check("sb_ill",   {31'd0, illegal_c_insn_id_o}, {31'd0, e.ill});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, instr_valid_id_o}, 32'd0);
        check({tag, "_rdata"}, instr_rdata_id_o, 32'd0);
        check({tag, "_pc"},    pc_id_o, 32'd0);
        check({tag, "_c"},     {31'd0, is_compressed_id_o}, 32'd0);
        check({tag, "_ill"},   {31'd0, illegal_c_insn_id_o}, 32'd0);
        check({tag, "_new"},   {31'd0, instr_new_id_o}, 32'd0);
        check({tag, "_cnt"},   fetch_cnt_o, 32'd0);
        check({tag, "_req"},   {31'd0, pf_req_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; boot_addr_i = 32'h0; pc_set_i = 1'b0;
        pc_mux_i = 2'd0; jump_target_i = 32'h0; exc_pc_i = 32'h0; epc_i = 32'h0;
        halt_if_i = 1'b0; id_ready_i = 1'b0; pf_valid_i = 1'b0;
        pf_rdata_i = 32'h0; pf_addr_i = 32'h0; pf_busy_i = 1'b0;
        cycle();
        cycle();
        #1;
        check_all_zero("rst");
        check("rst_busy", {31'd0, if_busy_o}, 32'd0);

        // Boot: IDLE -> BOOT (one cycle) -> RUN.
        rst = 1'b0; req_i = 1'b1; boot_addr_i = 32'h0000_0083;
        #1;
        check("idle_req",    {31'd0, pf_req_o}, 32'd0);
        check("idle_branch", {31'd0, pf_branch_o}, 32'd0);
        cycle();
        check("boot_branch", {31'd0, pf_branch_o}, 32'd1);
        check("boot_addr",   pf_addr_o, 32'h0000_0080);
        check("boot_req",    {31'd0, pf_req_o}, 32'd1);
        check("boot_busy",   {31'd0, if_busy_o}, 32'd1);
        cycle();
        check("run_branch",  {31'd0, pf_branch_o}, 32'd0);
        check("run_addr",    pf_addr_o, 32'd0);
        check("run_req",     {31'd0, pf_req_o}, 32'd1);
        check("run_busy",    {31'd0, if_busy_o}, 32'd0);

        // Back-to-back transfers with ID always ready.
        id_ready_i = 1'b1;
        offer(32'h0000_4501, 32'h0000_0080, 1'b1, 1'b0);
        #1 check("rdy_empty", {31'd0, pf_ready_o}, 32'd1);
        cycle();
        check("lat1_valid", {31'd0, instr_valid_id_o}, 32'd1);
        check("lat1_new",   {31'd0, instr_new_id_o}, 32'd1);
        offer(32'hFFFF_0000, 32'h0000_0082, 1'b1, 1'b1);
        #1 check("rdy_full_ack", {31'd0, pf_ready_o}, 32'd1);
        cycle();
        offer(32'h0010_0093, 32'h0000_0084, 1'b0, 1'b0);
        cycle();

        // ID stalls: no acceptance, register held.
        id_ready_i = 1'b0; pf_rdata_i = 32'hDEAD_BEEF; pf_addr_i = 32'h0000_0088;
        #1 check("rdy_stall", {31'd0, pf_ready_o}, 32'd0);
        cycle();
        check("hold_valid", {31'd0, instr_valid_id_o}, 32'd1);
        check("hold_rdata", instr_rdata_id_o, 32'h0010_0093);
        check("hold_pc",    pc_id_o, 32'h0000_0084);
        check("hold_new",   {31'd0, instr_new_id_o}, 32'd0);

        // Halt: ID drains the register, nothing new enters.
        pf_valid_i = 1'b0; halt_if_i = 1'b1; id_ready_i = 1'b1;
        #1 check("rdy_halt_full", {31'd0, pf_ready_o}, 32'd0);
        cycle();
        check("halt_drain", {31'd0, instr_valid_id_o}, 32'd0);
        check("halt_rdata", instr_rdata_id_o, 32'h0010_0093);
        check("rdy_halt_empty", {31'd0, pf_ready_o}, 32'd0);
        halt_if_i = 1'b0;
        #1 check("rdy_unhalt", {31'd0, pf_ready_o}, 32'd1);

        // Load one more, then flush with an exception redirect.
        offer(32'h0000_0013, 32'h0000_0088, 1'b0, 1'b0);
        cycle();
        pc_set_i = 1'b1; pc_mux_i = 2'd2; exc_pc_i = 32'h0000_1001;
        jump_target_i = 32'h0000_2003; epc_i = 32'h0000_3005;
        pf_rdata_i = 32'h1111_1111; pf_addr_i = 32'h0000_008C;
        #1;
        check("exc_branch", {31'd0, pf_branch_o}, 32'd1);
        check("exc_addr",   pf_addr_o, 32'h0000_1000);
        check("exc_ready",  {31'd0, pf_ready_o}, 32'd0);
        pc_mux_i = 2'd1;
        #1 check("jump_addr", pf_addr_o, 32'h0000_2002);
        pc_mux_i = 2'd3;
        #1 check("epc_addr",  pf_addr_o, 32'h0000_3004);
        pc_mux_i = 2'd0;
        #1 check("pcboot_addr", pf_addr_o, 32'h0000_0080);
        cycle();
        check("flush_valid", {31'd0, instr_valid_id_o}, 32'd0);
        check("flush_new",   {31'd0, instr_new_id_o}, 32'd0);
        check("flush_keep",  instr_rdata_id_o, 32'h0000_0013);

        // Flush also wins when ID is not ready.
        pc_set_i = 1'b0;
        offer(32'h0000_0001, 32'h0000_1000, 1'b1, 1'b0);
        cycle();
        pf_valid_i = 1'b0; id_ready_i = 1'b0; pc_set_i = 1'b1;
        cycle();
        check("flush_nordy", {31'd0, instr_valid_id_o}, 32'd0);
        pc_set_i = 1'b0;
`ifdef FLEXBEX_IF_FETCH_CNT_EN
        check("fetch_cnt", fetch_cnt_o, 32'(n_xfer));
`else
        check("fetch_cnt", fetch_cnt_o, 32'd0);
`endif

        // RUN with req_i low stays in RUN.
        req_i = 1'b0;
        #1 check("run_noreq", {31'd0, pf_req_o}, 32'd0);
        cycle();
        req_i = 1'b1;
        #1;
        check("run_reqback", {31'd0, pf_req_o}, 32'd1);
        check("run_noboot",  {31'd0, if_busy_o}, 32'd0);

        // Reset mid-stream has priority over a pending transfer.
        rst = 1'b1; id_ready_i = 1'b1;
        pf_valid_i = 1'b1; pf_rdata_i = 32'h0000_0093; pf_addr_i = 32'h0000_0100;
        cycle();
        pf_valid_i = 1'b0; req_i = 1'b0;
        #1;
        check_all_zero("mrst");

        // IDLE with request and redirect together goes straight to RUN.
        rst = 1'b0; req_i = 1'b1; pc_set_i = 1'b1; pc_mux_i = 2'd1;
        #1;
        check("idle_pcset_branch", {31'd0, pf_branch_o}, 32'd1);
        check("idle_pcset_addr",   pf_addr_o, 32'h0000_2002);
        check("idle_pcset_req",    {31'd0, pf_req_o}, 32'd0);
        cycle();
        pc_set_i = 1'b0;
        #1;
        check("skip_boot_busy", {31'd0, if_busy_o}, 32'd0);
        check("skip_boot_req",  {31'd0, pf_req_o}, 32'd1);
        check("skip_boot_br",   {31'd0, pf_branch_o}, 32'd0);
        pf_busy_i = 1'b1;
        #1 check("busy_pass", {31'd0, if_busy_o}, 32'd1);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
